// File: rtl/control_game_hist_if.sv
// -----------------------------------------------------------------------------
// control_game_hist_if
// Purpose : bundles the game-control signals between the keypad/number-entry
//           logic (master) and the game controller (slave).
//
// Handshake: iSecretLd and iNumRdy are single-cycle request pulses with no
//            back-pressure. iSecretLd is always honoured. iNumRdy is accepted
//            only while the controller is in READY. A pulse that arrives while
//            oBusy, oWin or oLose is high is dropped, not queued. The master
//            must therefore watch oBusy, oWin and oLose before it pulses
//            iNumRdy.
//
// Signals:
//   iSecret    m->s  secret, digit 0 in [3:0]
//   iSecretLd  m->s  pulse: load secret, clear history, start game
//   iGuess     m->s  guess, same packing as iSecret
//   iNumRdy    m->s  pulse: iGuess valid
//   iHistSel   m->s  history slot selected for read-back
//   oBusy      s->m  high while a guess is being scored or written
//   oHitA      s->m  EXACT count of the last scored guess
//   oHitB      s->m  PRESENT count of the last scored guess
//   oTries     s->m  number of stored guesses
//   oWin       s->m  game won
//   oLose      s->m  game lost
//   oState     s->m  FSM state, for debug
//   oHistGuess s->m  stored guess at iHistSel
//   oHistStat  s->m  stored 2-bit-per-digit status at iHistSel
// -----------------------------------------------------------------------------
interface control_game_hist_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] iSecret;
    logic                    iSecretLd;
    logic [4*NUM_DIGITS-1:0] iGuess;
    logic                    iNumRdy;
    logic [3:0]              iHistSel;
    logic                    oBusy;
    logic [3:0]              oHitA;
    logic [3:0]              oHitB;
    logic [3:0]              oTries;
    logic                    oWin;
    logic                    oLose;
    logic [2:0]              oState;
    logic [4*NUM_DIGITS-1:0] oHistGuess;
    logic [2*NUM_DIGITS-1:0] oHistStat;

    modport master (
        output iSecret, iSecretLd, iGuess, iNumRdy, iHistSel,
        input  oBusy, oHitA, oHitB, oTries, oWin, oLose, oState,
               oHistGuess, oHistStat
    );

    modport slave (
        input  iSecret, iSecretLd, iGuess, iNumRdy, iHistSel,
        output oBusy, oHitA, oHitB, oTries, oWin, oLose, oState,
               oHistGuess, oHistStat
    );
endinterface

// File: rtl/control_game_hist.sv
// -----------------------------------------------------------------------------
// control_game_hist
// Purpose : holds a NUM_DIGITS BCD secret and scores guesses one digit per
//           cycle as EXACT / PRESENT / MISS. It keeps up to HIST_DEPTH scored
//           guesses and draws them as a coloured cell grid on the VGA pixel
//           stream, with a win/lose frame at the screen edge.
//
// Ports:
//   clk      pixel clock
//   reset    synchronous, active-high
//   pix_x    current pixel column (0..639)
//   pix_y    current pixel row (0..479)
//   rgb_on   video active; 0 forces black
//   out_rgb  registered pixel colour {R,G,B}, 1-cycle latency from pix_x/pix_y
//   gif      control_game_hist_if.slave: secret/guess entry, score, status
//
// Grid layout: row r holds history slot r. The leftmost column shows the most
// significant digit, so a guess reads left-to-right as it was typed.
// -----------------------------------------------------------------------------
module control_game_hist #(
    parameter int NUM_DIGITS = 4,
    parameter int HIST_DEPTH = 8,
    parameter int CELL_SHIFT = 5,
    parameter int X0         = 64,
    parameter int Y0         = 64,
    parameter int BORDER     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic                  rgb_on,
    output logic [2:0]            out_rgb,
    control_game_hist_if.slave    gif
);

    localparam int CS     = 1 << CELL_SHIFT;
    localparam int GRID_W = NUM_DIGITS * CS;
    localparam int GRID_H = HIST_DEPTH * CS;
    localparam int KW     = $clog2(NUM_DIGITS);

    // Per-digit status codes
    localparam logic [1:0] ST_MISS    = 2'b00;
    localparam logic [1:0] ST_PRESENT = 2'b01;
    localparam logic [1:0] ST_EXACT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READY   = 3'd1,
        S_COMPARE = 3'd2,
        S_WRITE   = 3'd3,
        S_WIN     = 3'd4,
        S_LOSE    = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [4*NUM_DIGITS-1:0] secret_q;
    logic [4*NUM_DIGITS-1:0] guess_q;
    logic [2*NUM_DIGITS-1:0] stat_q;      // statuses scored so far for guess_q
    logic [KW-1:0]           k_q;         // digit being scored in COMPARE
    logic [3:0]              tries_q;
    logic [3:0]              hit_a_q;
    logic [3:0]              hit_b_q;
    logic [4*NUM_DIGITS-1:0] hist_guess_q [HIST_DEPTH];
    logic [2*NUM_DIGITS-1:0] hist_stat_q  [HIST_DEPTH];
    logic [2:0]              rgb_q;

    // -------------------------------------------------------------------------
    // Scoring of the current digit k_q
    // -------------------------------------------------------------------------
    logic [1:0] cur_stat;

    always_comb begin
        cur_stat = ST_MISS;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (k_q == KW'(i)) begin
                if (guess_q[4*i +: 4] == secret_q[4*i +: 4]) begin
                    cur_stat = ST_EXACT;
                end else begin
                    // Any match elsewhere counts; repeated digits are not
                    // matched off against each other.
                    for (int j = 0; j < NUM_DIGITS; j++) begin
                        if (j != i && guess_q[4*i +: 4] == secret_q[4*j +: 4]) begin
                            cur_stat = ST_PRESENT;
                        end
                    end
                end
            end
        end
    end

    // Totals of the fully scored guess, consumed in WRITE
    logic [3:0] count_a;
    logic [3:0] count_b;
    logic [3:0] tries_inc;

    always_comb begin
        count_a = 4'd0;
        count_b = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (stat_q[2*i +: 2] == ST_EXACT) begin
                count_a = count_a + 4'd1;
            end
            if (stat_q[2*i +: 2] == ST_PRESENT) begin
                count_b = count_b + 4'd1;
            end
        end
        tries_inc = tries_q + 4'd1;
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (gif.iSecretLd) begin
            // A secret load restarts the game from any state and drops any
            // guess in flight, including one arriving in the same cycle.
            state_d = S_READY;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_READY:   if (gif.iNumRdy) state_d = S_COMPARE;
                S_COMPARE: if (k_q == KW'(NUM_DIGITS - 1)) state_d = S_WRITE;
                S_WRITE: begin
                    if (count_a == 4'(NUM_DIGITS)) begin
                        state_d = S_WIN;
                    end else if (tries_inc == 4'(HIST_DEPTH)) begin
                        state_d = S_LOSE;
                    end else begin
                        state_d = S_READY;
                    end
                end
                S_WIN:     state_d = S_WIN;
                S_LOSE:    state_d = S_LOSE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            secret_q <= '0;
            guess_q  <= '0;
            stat_q   <= '0;
            k_q      <= '0;
            tries_q  <= 4'd0;
            hit_a_q  <= 4'd0;
            hit_b_q  <= 4'd0;
            for (int r = 0; r < HIST_DEPTH; r++) begin
                hist_guess_q[r] <= '0;
                hist_stat_q[r]  <= '0;
            end
        end else if (gif.iSecretLd) begin
            secret_q <= gif.iSecret;
            stat_q   <= '0;
            k_q      <= '0;
            tries_q  <= 4'd0;
            hit_a_q  <= 4'd0;
            hit_b_q  <= 4'd0;
            for (int r = 0; r < HIST_DEPTH; r++) begin
                hist_guess_q[r] <= '0;
                hist_stat_q[r]  <= '0;
            end
        end else begin
            case (state_q)
                S_READY: begin
                    if (gif.iNumRdy) begin
                        guess_q <= gif.iGuess;
                        stat_q  <= '0;
                        k_q     <= '0;
                    end
                end
                S_COMPARE: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (k_q == KW'(i)) begin
                            stat_q[2*i +: 2] <= cur_stat;
                        end
                    end
                    k_q <= k_q + KW'(1);
                end
                S_WRITE: begin
                    for (int r = 0; r < HIST_DEPTH; r++) begin
                        if (tries_q == 4'(r)) begin
                            hist_guess_q[r] <= guess_q;
                            hist_stat_q[r]  <= stat_q;
                        end
                    end
                    tries_q <= tries_inc;
                    hit_a_q <= count_a;
                    hit_b_q <= count_b;
                end
                default: ;
            endcase
        end
    end

    // History read-back
    always_comb begin
        gif.oHistGuess = '0;
        gif.oHistStat  = '0;
        for (int r = 0; r < HIST_DEPTH; r++) begin
            if (gif.iHistSel == 4'(r)) begin
                gif.oHistGuess = hist_guess_q[r];
                gif.oHistStat  = hist_stat_q[r];
            end
        end
    end

    assign gif.oBusy  = (state_q == S_COMPARE) || (state_q == S_WRITE);
    assign gif.oHitA  = hit_a_q;
    assign gif.oHitB  = hit_b_q;
    assign gif.oTries = tries_q;
    assign gif.oWin   = (state_q == S_WIN);
    assign gif.oLose  = (state_q == S_LOSE);
    assign gif.oState = state_q;

    // -------------------------------------------------------------------------
    // Pixel renderer
    // -------------------------------------------------------------------------
    logic [9:0] dx, dy, col, row;
    logic       in_grid, on_line, in_frame, cell_used;
    logic [1:0] cell_stat;
    logic [2:0] rgb_d;

    always_comb begin
        dx        = pix_x - 10'(X0);
        dy        = pix_y - 10'(Y0);
        col       = dx >> CELL_SHIFT;
        row       = dy >> CELL_SHIFT;
        in_grid   = (pix_x >= 10'(X0)) && (dx < 10'(GRID_W)) &&
                    (pix_y >= 10'(Y0)) && (dy < 10'(GRID_H));
        // Last pixel of each cell pitch is the 1-px grid line.
        on_line   = (dx[CELL_SHIFT-1:0] == '1) || (dy[CELL_SHIFT-1:0] == '1);
        in_frame  = (pix_x < 10'(BORDER)) || (pix_x > 10'(639 - BORDER)) ||
                    (pix_y < 10'(BORDER)) || (pix_y > 10'(479 - BORDER));
        cell_stat = ST_MISS;
        cell_used = 1'b0;
        for (int r = 0; r < HIST_DEPTH; r++) begin
            for (int c = 0; c < NUM_DIGITS; c++) begin
                if (row == 10'(r) && col == 10'(c)) begin
                    cell_stat = hist_stat_q[r][2*(NUM_DIGITS-1-c) +: 2];
                    cell_used = (4'(r) < tries_q);
                end
            end
        end

        rgb_d = 3'b000;
        if (in_grid && !on_line) begin
            if (cell_used) begin
                case (cell_stat)
                    ST_EXACT:   rgb_d = 3'b010;
                    ST_PRESENT: rgb_d = 3'b110;
                    default:    rgb_d = 3'b100;
                endcase
            end else begin
                rgb_d = 3'b001;
            end
        end
        if (in_frame && state_q == S_WIN) begin
            rgb_d = 3'b111;
        end else if (in_frame && state_q == S_LOSE) begin
            rgb_d = 3'b100;
        end
        if (!rgb_on) begin
            rgb_d = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= 3'b000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign out_rgb = rgb_q;

endmodule

// File: tb/tb_control_game_hist.sv
module tb_control_game_hist;
    localparam int ND = 4;
    localparam int W  = 14;   // {hitA, hitB, tries, win, lose}

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       rgb_on;
    logic [2:0] out_rgb;

    control_game_hist_if #(.NUM_DIGITS(ND)) gif ();

    control_game_hist #(
        .NUM_DIGITS(ND), .HIST_DEPTH(8), .CELL_SHIFT(5),
        .X0(64), .Y0(64), .BORDER(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pix_x   (pix_x),
        .pix_y   (pix_y),
        .rgb_on  (rgb_on),
        .out_rgb (out_rgb),
        .gif     (gif.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic         prev_busy = 1'b0;
    logic [W-1:0] exp_e;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !gif.oBusy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL result: DUT finished a guess with no expectation queued");
                end else begin
                    exp_e = exp_q.pop_front();
                    check("result", {18'd0, gif.oHitA, gif.oHitB, gif.oTries, gif.oWin, gif.oLose},
                          {18'd0, exp_e});
                end
            end
            prev_busy = gif.oBusy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_secret(input logic [15:0] s);
        gif.iSecret   = s;
        gif.iSecretLd = 1'b1;
        step();
        gif.iSecretLd = 1'b0;
    endtask

    task automatic pulse_guess(input logic [15:0] g);
        gif.iGuess  = g;
        gif.iNumRdy = 1'b1;
        step();
        gif.iNumRdy = 1'b0;
    endtask

    task automatic do_guess(input logic [15:0] g, input int a, input int b,
                            input int tries, input bit win, input bit lose);
        int n;
        exp_q.push_back({4'(a), 4'(b), 4'(tries), win, lose});
        pulse_guess(g);
        n = 0;
        while (gif.oBusy && n < 40) begin
            step();
            n++;
        end
        check("latency", n, ND + 1);
    endtask

    // Guess while not accepting: must not start a compare nor change tries
    task automatic ignored_guess(input string name, input logic [15:0] g, input int tries);
        pulse_guess(g);
        check({name, "_busy"}, gif.oBusy, 0);
        repeat (ND + 3) step();
        check({name, "_tries"}, gif.oTries, tries);
    endtask

    task automatic pix(input string name, input int x, input int y, input logic [2:0] exp);
        pix_x  = 10'(x);
        pix_y  = 10'(y);
        rgb_on = 1'b1;
        step();
        check(name, out_rgb, exp);
    endtask

    // cell centre helpers (cell pitch 32, origin 64)
    function automatic int cx(input int c); return 64 + c*32 + 5; endfunction
    function automatic int cy(input int r); return 64 + r*32 + 5; endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b1;
        pix_x         = 10'd0;
        pix_y         = 10'd0;
        rgb_on        = 1'b0;
        gif.iSecret   = '0;
        gif.iSecretLd = 1'b0;
        gif.iGuess    = '0;
        gif.iNumRdy   = 1'b0;
        gif.iHistSel  = 4'd0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_tries", gif.oTries, 0);
        check("rst_flags", {gif.oBusy, gif.oWin, gif.oLose}, 0);
        check("rst_hits", {gif.oHitA, gif.oHitB}, 0);
        check("rst_state", gif.oState, 0);
        check("rst_rgb", out_rgb, 0);
        pix("rst_cell00", cx(0), cy(0), 3'b001);
        rgb_on = 1'b0;
        step();
        check("rgb_off", out_rgb, 0);
        ignored_guess("idle_guess", 16'h1234, 0);

        // Game 1: score patterns, then win
        load_secret(16'h1234);
        check("ready_state", gif.oState, 1);
        do_guess(16'h1243, 2, 2, 1, 0, 0);
        gif.iHistSel = 4'd0;
        #1;
        check("hist_guess0", gif.oHistGuess, 16'h1243);
        pix("row0_c0", cx(0), cy(0), 3'b010);
        pix("row0_c1", cx(1), cy(0), 3'b010);
        pix("row0_c2", cx(2), cy(0), 3'b110);
        pix("row0_c3", cx(3), cy(0), 3'b110);
        pix("row1_unused", cx(0), cy(1), 3'b001);
        pix("grid_line", 95, cy(0), 3'b000);
        pix("outside", 300, 300, 3'b000);
        do_guess(16'h5678, 0, 0, 2, 0, 0);
        pix("row1_miss", cx(0), cy(1), 3'b100);
        do_guess(16'h4321, 0, 4, 3, 0, 0);
        pix("row2_present", cx(3), cy(2), 3'b110);
        do_guess(16'h1234, 4, 0, 4, 1, 0);
        pix("win_frame", 2, 2, 3'b111);
        pix("win_frame_br", 635, 475, 3'b111);
        ignored_guess("win_guess", 16'h1243, 4);

        // Game 2: eight misses -> lose
        load_secret(16'h1234);
        check("reload_tries", gif.oTries, 0);
        check("reload_win", gif.oWin, 0);
        do_guess(16'h5678, 0, 0, 1, 0, 0);
        do_guess(16'hFFF4, 1, 0, 2, 0, 0);
        do_guess(16'h1243, 2, 2, 3, 0, 0);
        do_guess(16'h4321, 0, 4, 4, 0, 0);
        do_guess(16'h1111, 1, 3, 5, 0, 0);
        do_guess(16'h9999, 0, 0, 6, 0, 0);
        do_guess(16'h2134, 2, 2, 7, 0, 0);
        do_guess(16'h1235, 3, 0, 8, 0, 1);
        pix("lose_frame", 2, 2, 3'b100);
        pix("row7_c0", cx(0), cy(7), 3'b010);
        pix("row7_c3", cx(3), cy(7), 3'b100);
        ignored_guess("lose_guess", 16'h1234, 8);

        // Game 3: win on the last slot
        load_secret(16'h1234);
        for (int i = 0; i < 7; i++) begin
            do_guess(16'h5678, 0, 0, i + 1, 0, 0);
        end
        do_guess(16'h1234, 4, 0, 8, 1, 0);

        // Abort an in-flight compare
        load_secret(16'h1234);
        do_guess(16'h1243, 2, 2, 1, 0, 0);
        exp_q.push_back('0);     // abort leaves the cleared game visible
        pulse_guess(16'h5678);
        step();
        step();
        check("abort_busy_pre", gif.oBusy, 1);
        load_secret(16'h9876);
        check("abort_busy", gif.oBusy, 0);
        check("abort_tries", gif.oTries, 0);
        pix("abort_row0_c0", cx(0), cy(0), 3'b001);
        pix("abort_row0_c3", cx(3), cy(0), 3'b001);
        repeat (ND + 2) step();
        check("abort_tries_late", gif.oTries, 0);

        // Secret load and guess in the same cycle: guess dropped
        gif.iGuess    = 16'h9876;
        gif.iNumRdy   = 1'b1;
        gif.iSecret   = 16'h9876;
        gif.iSecretLd = 1'b1;
        step();
        gif.iNumRdy   = 1'b0;
        gif.iSecretLd = 1'b0;
        check("same_cycle_busy", gif.oBusy, 0);
        repeat (ND + 2) step();
        check("same_cycle_tries", gif.oTries, 0);

        repeat (3) step();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
